// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one byte-wide memory port between the CPU MEM stage and an external
// loader/debug requester. Each 32-bit word access becomes four big-endian byte
// beats (MSB at the base address). Arbitration is round-robin and non-preemptive.
//
// Handshake: a requester raises *_req with *_we/*_addr/*_wdata stable and holds
// it until it samples *_done=1 on a rising edge, then drops req at that same
// edge. *_done is a single-cycle pulse; a req still high in the IDLE cycle after
// DONE starts a new transaction. Inputs are latched at grant, so changes made
// during a transaction have no effect on it.
`timescale 1ns/1ps
module mem_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int BYTES  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [31:0]       ext_wdata,
  output logic [31:0]       ext_rdata,
  output logic              ext_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic              mem_re,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XFER  = 2'd1,
    RTAIL = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] LAST_BEAT = 2'(BYTES - 1);

  state_t              state_q, state_d;
  logic                start;        // grant happens this cycle
  logic                grant_ext;    // granted requester is ext
  logic                owner_q;      // 1 = ext owns the current transaction
  logic                last_ext_q;   // 1 = ext was served last (reset: CPU wins next)
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [1:0]          beat_q;
  logic                rd_pend_q;    // a read byte arrives on mem_rdata this cycle
  logic [23:0]         rbuf_q;       // first three read bytes, MSB first
  logic [31:0]         cpu_rdata_q;
  logic [31:0]         ext_rdata_q;
  logic                xfer;

  // Next-state and grant decision.
  always_comb begin
    state_d   = state_q;
    start     = 1'b0;
    grant_ext = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_req || ext_req) begin
          start     = 1'b1;
          // When both ask, serve whoever was not served last.
          grant_ext = ext_req & (~cpu_req | ~last_ext_q);
          state_d   = XFER;
        end
      end
      XFER: begin
        if (beat_q == LAST_BEAT) begin
          state_d = we_q ? DONE : RTAIL;
        end
      end
      RTAIL:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register plus the transaction latched at grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_ext_q <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      beat_q     <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        owner_q <= grant_ext;
        we_q    <= grant_ext ? ext_we    : cpu_we;
        addr_q  <= grant_ext ? ext_addr  : cpu_addr;
        wdata_q <= grant_ext ? ext_wdata : cpu_wdata;
        beat_q  <= '0;
      end else if (state_q == XFER) begin
        beat_q <= beat_q + 2'd1;
      end
      if (state_q == DONE) begin
        last_ext_q <= owner_q;
      end
    end
  end

  // Read assembly: each byte is captured one cycle after its strobe; the last
  // byte lands in RTAIL and the owner's word register is loaded on that edge so
  // it is valid together with the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_q   <= 1'b0;
      rbuf_q      <= '0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      rd_pend_q <= mem_re;
      if (rd_pend_q) begin
        rbuf_q <= {rbuf_q[15:0], mem_rdata};
      end
      if (state_q == RTAIL) begin
        if (owner_q) ext_rdata_q <= {rbuf_q, mem_rdata};
        else         cpu_rdata_q <= {rbuf_q, mem_rdata};
      end
    end
  end

  // Byte-lane select for the current write beat, MSB first.
  always_comb begin
    mem_wdata = 8'h00;
    if (xfer) begin
      case (beat_q)
        2'd0:    mem_wdata = wdata_q[31:24];
        2'd1:    mem_wdata = wdata_q[23:16];
        2'd2:    mem_wdata = wdata_q[15:8];
        default: mem_wdata = wdata_q[7:0];
      endcase
    end
  end

  assign xfer      = (state_q == XFER);
  assign mem_addr  = xfer ? (addr_q + ADDR_W'(beat_q)) : '0;
  assign mem_we    = xfer &  we_q;
  assign mem_re    = xfer & ~we_q;
  assign cpu_done  = (state_q == DONE) & ~owner_q;
  assign ext_done  = (state_q == DONE) &  owner_q;
  assign cpu_stall = cpu_req & ~cpu_done;
  assign cpu_rdata = cpu_rdata_q;
  assign ext_rdata = ext_rdata_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter with a byte memory model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int ADDR_W = 7;

  logic              clk;
  logic              reset;
  logic              cpu_req, cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata, cpu_rdata;
  logic              cpu_done, cpu_stall;
  logic              ext_req, ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_wdata, ext_rdata;
  logic              ext_done;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we, mem_re;
  logic [7:0]        mem_wdata, mem_rdata;
  logic [1:0]        dbg_state;

  int errors = 0;
  int checks = 0;
  logic [0:0] exp_q[$];   // expected grant order: 0 = CPU, 1 = ext

  logic [7:0] mem [0:127];

  mem_port_arbiter #(.ADDR_W(ADDR_W), .BYTES(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_done(ext_done),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .dbg_state(dbg_state)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memory, one-cycle read latency
  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem_rdata = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  // Strobes must never overlap
  always @(negedge clk) begin
    if (!reset) begin
      checks++;
      if (mem_we && mem_re) begin
        errors++;
        $display("FAIL strobe_overlap: mem_we=%0b mem_re=%0b required not both 1", mem_we, mem_re);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: ext transaction, waits for ext_done within a budget
  task automatic run_ext(input logic we, input logic [6:0] addr, input logic [31:0] data);
    bit seen = 0;
    ext_we = we; ext_addr = addr; ext_wdata = data; ext_req = 1'b1;
    for (int c = 0; c < 20 && !seen; c++) begin
      step();
      if (ext_done) seen = 1;
    end
    ext_req = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL run_ext_timeout: ext_done=0 required 1 within 20 cycles");
    end
    step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    checks++; if ({mem_we, mem_re} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b want 00", {mem_we, mem_re}); end
    checks++; if (mem_addr !== 7'h00 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus: addr=%h wdata=%h want 0,0", mem_addr, mem_wdata); end
    checks++; if ({cpu_done, ext_done, cpu_stall} !== 3'b000) begin errors++; $display("FAIL reset_done: got %b want 000", {cpu_done, ext_done, cpu_stall}); end
    checks++; if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: cpu=%h ext=%h want 0,0", cpu_rdata, ext_rdata); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_cpu_write();
    logic [7:0] eb [4];
    eb[0] = 8'hDE; eb[1] = 8'hAD; eb[2] = 8'hBE; eb[3] = 8'hEF;
    cpu_we = 1'b1; cpu_addr = 7'h10; cpu_wdata = 32'hDEADBEEF; cpu_req = 1'b1;
    #1;
    checks++; if (cpu_stall !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL wr_cycle0: stall=%b we=%b want 1,0", cpu_stall, mem_we); end
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        checks++;
        if (mem_we !== 1'b1 || mem_re !== 1'b0 || mem_addr !== 7'(7'h10 + c - 1) || mem_wdata !== eb[c-1]
            || cpu_done !== 1'b0 || cpu_stall !== 1'b1) begin
          errors++;
          $display("FAIL wr_beat%0d: we=%b re=%b addr=%h data=%h done=%b stall=%b want 1,0,%h,%h,0,1",
                   c, mem_we, mem_re, mem_addr, mem_wdata, cpu_done, cpu_stall, 7'(7'h10 + c - 1), eb[c-1]);
        end
      end else begin
        checks++;
        if (cpu_done !== 1'b1 || mem_we !== 1'b0 || cpu_stall !== 1'b0) begin
          errors++;
          $display("FAIL wr_done: done=%b we=%b stall=%b want 1,0,0", cpu_done, mem_we, cpu_stall);
        end
      end
    end
    cpu_req = 1'b0;
    step();
    checks++;
    if ({mem[16], mem[17], mem[18], mem[19]} !== 32'hDEADBEEF) begin
      errors++; $display("FAIL wr_mem: got %h want deadbeef", {mem[16], mem[17], mem[18], mem[19]});
    end
    checks++; if (cpu_done !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL wr_after: done=%b state=%0d want 0,0", cpu_done, dbg_state); end
  endtask

  task automatic test_cpu_read();
    cpu_we = 1'b0; cpu_addr = 7'h10; cpu_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c <= 4) begin
        checks++;
        if (mem_re !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 7'(7'h10 + c - 1) || cpu_done !== 1'b0) begin
          errors++; $display("FAIL rd_beat%0d: re=%b we=%b addr=%h done=%b want 1,0,%h,0", c, mem_re, mem_we, mem_addr, cpu_done, 7'(7'h10 + c - 1));
        end
      end else if (c == 5) begin
        checks++;
        if (mem_re !== 1'b0 || cpu_done !== 1'b0 || cpu_stall !== 1'b1) begin
          errors++; $display("FAIL rd_tail: re=%b done=%b stall=%b want 0,0,1", mem_re, cpu_done, cpu_stall);
        end
      end else begin
        checks++;
        if (cpu_done !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin
          errors++; $display("FAIL rd_done: done=%b rdata=%h want 1,deadbeef", cpu_done, cpu_rdata);
        end
      end
    end
    cpu_req = 1'b0;
    step();
    checks++; if (cpu_rdata !== 32'hDEADBEEF || cpu_done !== 1'b0) begin errors++; $display("FAIL rd_hold: rdata=%h done=%b want deadbeef,0", cpu_rdata, cpu_done); end
  endtask

  task automatic test_both_from_reset();
    logic [0:0] exp_who;
    logic [0:0] got_who;
    bit seen;
    reset = 1'b1;
    cpu_we = 1'b1; cpu_addr = 7'h30; cpu_wdata = 32'hA0A1A2A3; cpu_req = 1'b1;
    ext_we = 1'b1; ext_addr = 7'h50; ext_wdata = 32'hB0B1B2B3; ext_req = 1'b1;
    exp_q.push_back(1'b0); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
    step(); step();
    reset = 1'b0;
    while (exp_q.size() > 0) begin
      exp_who = exp_q.pop_front();
      seen = 0;
      got_who = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
        step();
        if (cpu_done || ext_done) begin
          seen = 1;
          got_who = ext_done;
        end
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL both_timeout: no done within 20 cycles, want owner %0d", exp_who);
      end else if (got_who !== exp_who) begin
        errors++; $display("FAIL both_order: owner=%0d want %0d", got_who, exp_who);
      end
    end
    cpu_req = 1'b0; ext_req = 1'b0;
    step();
    checks++;
    if ({mem[48], mem[51], mem[80], mem[83]} !== 32'hA0A3B0B3) begin
      errors++; $display("FAIL both_mem: got %h want a0a3b0b3", {mem[48], mem[51], mem[80], mem[83]});
    end
  endtask

  task automatic test_wrap();
    logic [6:0] ea [4];
    logic [7:0] eb [4];
    ea[0] = 7'h7E; ea[1] = 7'h7F; ea[2] = 7'h00; ea[3] = 7'h01;
    eb[0] = 8'h01; eb[1] = 8'h02; eb[2] = 8'h03; eb[3] = 8'h04;
    ext_we = 1'b1; ext_addr = 7'h7E; ext_wdata = 32'h01020304; ext_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      step();
      if (c <= 4) begin
        checks++;
        if (mem_addr !== ea[c-1] || mem_wdata !== eb[c-1] || mem_we !== 1'b1 || ext_done !== 1'b0) begin
          errors++; $display("FAIL wrap_beat%0d: addr=%h data=%h we=%b done=%b want %h,%h,1,0", c, mem_addr, mem_wdata, mem_we, ext_done, ea[c-1], eb[c-1]);
        end
      end else begin
        checks++;
        if (ext_done !== 1'b1 || cpu_done !== 1'b0) begin
          errors++; $display("FAIL wrap_done: ext_done=%b cpu_done=%b want 1,0", ext_done, cpu_done);
        end
      end
    end
    ext_req = 1'b0;
    step();
    checks++;
    if ({mem[126], mem[127], mem[0], mem[1]} !== 32'h01020304) begin
      errors++; $display("FAIL wrap_mem: got %h want 01020304", {mem[126], mem[127], mem[0], mem[1]});
    end
  endtask

  task automatic test_reset_mid();
    cpu_we = 1'b1; cpu_addr = 7'h20; cpu_wdata = 32'h55667788; cpu_req = 1'b1;
    step();
    step();
    checks++; if (mem_we !== 1'b1 || mem_addr !== 7'h21) begin errors++; $display("FAIL rst_mid_pre: we=%b addr=%h want 1,21", mem_we, mem_addr); end
    reset = 1'b1; cpu_req = 1'b0;
    step();
    checks++; if (dbg_state !== 2'd0 || mem_we !== 1'b0 || mem_re !== 1'b0) begin errors++; $display("FAIL rst_mid_idle: state=%0d we=%b re=%b want 0,0,0", dbg_state, mem_we, mem_re); end
    checks++; if (mem_addr !== 7'h00 || mem_wdata !== 8'h00 || cpu_done !== 1'b0 || ext_done !== 1'b0) begin errors++; $display("FAIL rst_mid_outs: addr=%h wdata=%h cd=%b ed=%b want 0", mem_addr, mem_wdata, cpu_done, ext_done); end
    checks++; if (cpu_rdata !== 32'h0 || ext_rdata !== 32'h0) begin errors++; $display("FAIL rst_mid_rdata: cpu=%h ext=%h want 0,0", cpu_rdata, ext_rdata); end
    step();
    reset = 1'b0;
    step();
    checks++; if (cpu_done !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL rst_mid_nodone: done=%b we=%b want 0,0", cpu_done, mem_we); end
    checks++;
    if ({mem[32], mem[33], mem[34]} !== 24'h556600) begin
      errors++; $display("FAIL rst_mid_mem: got %h want 556600", {mem[32], mem[33], mem[34]});
    end
  endtask

  task automatic test_ext_read_cpu_pending();
    int wait_c;
    bit seen;
    run_ext(1'b1, 7'h40, 32'h11223344);
    ext_we = 1'b0; ext_addr = 7'h40; ext_req = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) begin
        cpu_we = 1'b0; cpu_addr = 7'h10; cpu_req = 1'b1;
      end else begin
        checks++;
        if (cpu_stall !== 1'b1 || cpu_done !== 1'b0 || cpu_rdata !== 32'h0) begin
          errors++; $display("FAIL xr_cpu_wait%0d: stall=%b done=%b rdata=%h want 1,0,0", c, cpu_stall, cpu_done, cpu_rdata);
        end
      end
      if (c == 6) begin
        checks++;
        if (ext_done !== 1'b1 || ext_rdata !== 32'h11223344) begin
          errors++; $display("FAIL xr_ext_done: done=%b rdata=%h want 1,11223344", ext_done, ext_rdata);
        end
      end
    end
    ext_req = 1'b0;
    seen = 0;
    wait_c = 0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      step();
      if (cpu_done) begin
        seen = 1;
        wait_c = c;
      end
    end
    checks++;
    if (!seen || wait_c != 7) begin
      errors++; $display("FAIL xr_cpu_latency: seen=%0d cycles=%0d want 1,7", seen, wait_c);
    end
    checks++;
    if (cpu_rdata !== 32'hDEADBEEF || ext_rdata !== 32'h11223344 || cpu_stall !== 1'b0) begin
      errors++; $display("FAIL xr_cpu_done: cpu=%h ext=%h stall=%b want deadbeef,11223344,0", cpu_rdata, ext_rdata, cpu_stall);
    end
    cpu_req = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_both_from_reset();
    test_wrap();
    test_reset_mid();
    test_ext_read_cpu_pending();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
